w_schedule: RTL
===============

// Module: w_schedule
// PURPOSE
//  SHA-256 message-schedule expander. Sits directly downstream of W_start.
//  Takes the 512-bit word-ordered block W (W_0 in bits [31:0], W_15 in bits [511:480]).
//  Streams W_0..W_{ROUNDS-1}, one 32-bit word per clock, to the compression-round stage.
//  Uses a 16-word sliding window, so the full 64-word schedule is never stored.
// PARAMETERS
//  ROUNDS   64   words emitted per block; legal range 16..64
// PORTS
//  clk       in   1    system clock, rising edge
//  reset     in   1    asynchronous, active-low reset
//  en        in   1    load request; samples W when the block is idle
//  W         in   512  message block from W_start, word t in bits [32t+31:32t]
//  w_t       out  32   current schedule word
//  w_idx     out  6    index t of w_t
//  w_valid   out  1    w_t/w_idx are valid this cycle
//  busy      out  1    block is streaming; en is ignored
//  en_next   out  1    one-cycle pulse: block finished, next stage may proceed
// BEHAVIOUR
//  Reset (reset==0, asynchronous): state=IDLE; all outputs and the window are 0.
//  FSM states: IDLE -> RUN -> DONE -> IDLE.
//   IDLE/DONE: en==1 at a rising edge loads window[0..15]=W, sets t=0, goes to RUN.
//   RUN: w_valid=1, busy=1, w_t=window[0], w_idx=t.
//    Each edge shifts the window by one word, appends the new word, and increments t.
//    On the edge where t==ROUNDS-1 is presented, goes to DONE.
//   DONE: en_next=1 and w_valid=0 for exactly one cycle; busy=0.
//    en in DONE is accepted and goes straight to RUN, so back-to-back blocks have a 1-cycle gap.
//  en while RUN: ignored; W is not resampled.
//  Latency: en at edge k -> W_0 valid in cycle k+1, W_{ROUNDS-1} in cycle k+ROUNDS,
//   en_next in cycle k+ROUNDS+1.
//  New word, all arithmetic mod 2^32 with carries discarded:
//   W_{t+16} = s1(W_{t+14}) + W_{t+9} + s0(W_{t+1}) + W_t
//   s0(x) = ror7 ^ ror18 ^ shr3;  s1(x) = ror17 ^ ror19 ^ shr10
//  Words for t<16 come out unchanged from W. The appended word is computed
//   combinationally from the window (one 4-input adder level).
//  All outputs are registered; no combinational path from en or W to any output.
//  reset asserted mid-block: aborts immediately, no en_next, back to IDLE.
// CONFIGURATION
//  W_SCHED_STALL_EN defined:
//   Adds input 'stall' (1 bit). stall==1 in RUN freezes the window, t and all outputs.
//   w_valid stays 1 with the same word. stall has no effect in IDLE/DONE.
//  W_SCHED_STALL_EN undefined: no stall port; the stream never pauses once started.
// TESTING
//  1. "abc" padded block (W_0=61626380, W_1..W_14=0, W_15=00000018), en 1 cycle
//     -> W_16=61626380, W_17=000f0000, W_18=7da86405, W_63=12b1edeb.
//     All 64 words must match the software model.
//  2. T1 block from W_start (W_0=02000000, W_1=671d0e2f, W_15=15a907c0)
//     -> W_0..W_15 echo the input exactly.
//     W_16..W_63 match the model; en_next exactly 65 cycles after en.
//  3. en held high continuously for 3 blocks -> busy never drops during RUN.
//     One w_valid=0 gap per block; en_next pulses 3 times, each 1 cycle wide.
//  4. en pulsed at t=10 with a different W -> stream unaffected; W of the first block
//     continues to W_63.
//  5. reset pulled low at t=30 -> next cycle w_valid=0, busy=0, no en_next.
//     A fresh en then restarts from W_0.
//  6. W_SCHED_STALL_EN: stall high for 5 cycles at t=20 -> w_t/w_idx=20 held for 5 cycles.
//     Total latency grows by 5; all words are still correct.

Source files
------------

// File: rtl/w_schedule.sv
// SHA-256 message-schedule expander: streams W_0..W_{ROUNDS-1}, one word per clock, from a 16-word window.
// Define W_SCHED_STALL_EN to add a 'stall' input that freezes the stream while running.
module w_schedule #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
`ifdef W_SCHED_STALL_EN
    input  logic         stall,
`endif
    input  logic [511:0] W,
    output logic [31:0]  w_t,
    output logic [5:0]   w_idx,
    output logic         w_valid,
    output logic         busy,
    output logic         en_next
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    logic [1:0]  state;
    logic [31:0] win [16];
    logic [5:0]  t_idx;
    logic [31:0] new_word;
    logic        hold;

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

`ifdef W_SCHED_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    // win[0] holds W_t, so W_{t+16} draws on W_{t+14}, W_{t+9}, W_{t+1} and W_t
    always_comb begin
        new_word = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0];
    end

    assign w_t   = win[0];
    assign w_idx = t_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            t_idx   <= '0;
            w_valid <= 1'b0;
            busy    <= 1'b0;
            en_next <= 1'b0;
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (!hold) begin
                        if (t_idx == LAST_IDX) begin
                            state   <= S_DONE;
                            w_valid <= 1'b0;
                            busy    <= 1'b0;
                            en_next <= 1'b1;
                        end else begin
                            for (int i = 0; i < 15; i++) win[i] <= win[i + 1];
                            win[15] <= new_word;
                            t_idx   <= t_idx + 6'd1;
                        end
                    end
                end
                // IDLE and DONE both accept a new block; DONE lasts exactly one cycle
                default: begin
                    en_next <= 1'b0;
                    if (en) begin
                        for (int i = 0; i < 16; i++) win[i] <= W[32*i +: 32];
                        state   <= S_RUN;
                        t_idx   <= '0;
                        w_valid <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        state   <= S_IDLE;
                        w_valid <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
